// File: rtl/soc_pkg.sv
// -----------------------------------------------------------------------------
// soc_pkg
// Shared definitions for the iomem peripheral block: register offsets,
// STATUS bit positions, UART serializer state encoding and a small helper
// used by the LED register byte-lane decode.
// No ports (package).
// -----------------------------------------------------------------------------
package soc_pkg;

    localparam int unsigned IOMEM_AW = 22;

    localparam logic [IOMEM_AW-1:0] REG_LEDS   = 22'h00_0004;
    localparam logic [IOMEM_AW-1:0] REG_TXDATA = 22'h00_0008;
    localparam logic [IOMEM_AW-1:0] REG_STATUS = 22'h00_000C;

    localparam int unsigned STAT_BUSY_BIT  = 0;
    localparam int unsigned STAT_FULL_BIT  = 1;
    localparam int unsigned STAT_EMPTY_BIT = 2;
    localparam int unsigned STAT_OVF_BIT   = 3;
    localparam int unsigned STAT_CNT_LSB   = 8;
    localparam int unsigned STAT_CNT_W     = 8;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

    // Byte lane of the write mask that governs a given data bit. Bits beyond
    // the 32-bit mask reach fall under the top lane.
    function automatic logic [1:0] led_byte_lane(input int unsigned bit_idx);
        return (bit_idx >= 24) ? 2'd3 : 2'(bit_idx / 8);
    endfunction

endpackage

// File: rtl/uart_tx_ser.sv
// -----------------------------------------------------------------------------
// uart_tx_ser
// 8N1 UART serializer, LSB first, BAUD_DIV clk cycles per bit.
// A byte is accepted when tx_valid & tx_ready. tx_ready is high in IDLE and on
// the last cycle of STOP, so a waiting byte starts with no idle gap.
//
// state | meaning
// IDLE  | line high, waiting for a byte
// START | start bit (line low)
// DATA  | 8 data bits, shift register LSB on the line
// STOP  | stop bit (line high)
//
// Ports:
//   clk      in   clock, posedge
//   resetn   in   synchronous active-low reset
//   tx_data  in   byte to send
//   tx_valid in   tx_data is available
//   tx_ready out  byte is taken this cycle if tx_valid
//   tx_busy  out  1 in every state except IDLE
//   tx_out   out  serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx_ser
    import soc_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 868
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_out
);

    localparam int unsigned BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LOAD = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

    uart_state_e state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          baud_tc;

    assign baud_tc = (baud_q == '0);

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= UART_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            UART_IDLE: begin
                if (tx_valid) begin
                    state_d = UART_START;
                    baud_d  = BAUD_LOAD;
                    shift_d = tx_data;
                end
            end
            UART_START: begin
                if (baud_tc) begin
                    state_d = UART_DATA;
                    baud_d  = BAUD_LOAD;
                    bit_d   = 3'd7;
                end else begin
                    baud_d = baud_q - BAUD_ONE;
                end
            end
            UART_DATA: begin
                if (baud_tc) begin
                    baud_d = BAUD_LOAD;
                    if (bit_q == 3'd0) begin
                        state_d = UART_STOP;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q - 3'd1;
                    end
                end else begin
                    baud_d = baud_q - BAUD_ONE;
                end
            end
            UART_STOP: begin
                if (baud_tc) begin
                    // Chain straight into the next start bit when a byte waits
                    if (tx_valid) begin
                        state_d = UART_START;
                        baud_d  = BAUD_LOAD;
                        shift_d = tx_data;
                    end else begin
                        state_d = UART_IDLE;
                    end
                end else begin
                    baud_d = baud_q - BAUD_ONE;
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        tx_ready = (state_q == UART_IDLE) || ((state_q == UART_STOP) && baud_tc);
        tx_busy  = (state_q != UART_IDLE);
        case (state_q)
            UART_START: tx_out = 1'b0;
            UART_DATA:  tx_out = shift_q[0];
            default:    tx_out = 1'b1;
        endcase
    end

endmodule

// File: rtl/soc_iomem.sv
// -----------------------------------------------------------------------------
// soc_iomem
// Memory-mapped I/O block: LED register, console TX FIFO feeding an 8N1 UART,
// and a STATUS register with a sticky overflow flag (write 1 to bit 3 clears).
//   0x4 LEDS   RW  low NUM_LEDS bits
//   0x8 TXDATA W   byte in wdata[7:0]
//   0xC STATUS R   bit0 busy, bit1 full, bit2 empty, bit3 overflow, [15:8] count
//
// Ports:
//   clk        in   clock, posedge
//   resetn     in   synchronous active-low reset
//   sel        in   iomem select
//   mem_addr   in   byte offset within iomem
//   mem_wdata  in   write data
//   mem_wmask  in   byte write mask; any set bit with sel is a write
//   mem_rstrb  in   read strobe
//   mem_rdata  out  read data, registered, holds between reads
//   leds       out  LED register
//   uart_tx    out  serial TX, idle high
//
// Build option: define SOC_IOMEM_SIM_PRINT_EN to echo each byte popped from
// the FIFO to the simulator console. UART behaviour is unaffected.
// Assumes XLEN >= 16 so the count field fits.
// -----------------------------------------------------------------------------
module soc_iomem
    import soc_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NUM_LEDS   = 4,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned BAUD_DIV   = 868
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                sel,
    input  logic [21:0]         mem_addr,
    input  logic [XLEN-1:0]     mem_wdata,
    input  logic [3:0]          mem_wmask,
    input  logic                mem_rstrb,
    output logic [XLEN-1:0]     mem_rdata,
    output logic [NUM_LEDS-1:0] leds,
    output logic                uart_tx
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    logic [NUM_LEDS-1:0] leds_q, leds_d;
    logic [XLEN-1:0]     rdata_q, rdata_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ovf_q, ovf_d;

    logic [7:0]          fifo_mem [FIFO_DEPTH];
    logic [7:0]          fifo_head;

    logic                wr_en, rd_en;
    logic                push_req, push, pop;
    logic                fifo_full, fifo_empty;
    logic                ovf_set, ovf_clr;
    logic [XLEN-1:0]     status_word;
    logic                ser_ready, ser_busy;
    logic                unused_wdata;

    assign unused_wdata = ^mem_wdata;

    assign wr_en      = sel & (|mem_wmask);
    assign rd_en      = sel & mem_rstrb;
    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CNT_FULL);
    assign fifo_head  = fifo_mem[rd_ptr_q];

    always_comb begin
        push_req = wr_en && (mem_addr == REG_TXDATA);
        pop      = ser_ready && !fifo_empty;
        // A full FIFO still accepts a byte when the head leaves the same cycle
        push     = push_req && (!fifo_full || pop);
        ovf_set  = push_req && fifo_full && !pop;
        ovf_clr  = wr_en && (mem_addr == REG_STATUS) && mem_wdata[STAT_OVF_BIT];
        // Set wins over a simultaneous clear
        ovf_d    = ovf_set | (ovf_q & ~ovf_clr);

        wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        leds_d = leds_q;
        if (wr_en && (mem_addr == REG_LEDS)) begin
            for (int i = 0; i < int'(NUM_LEDS); i++) begin
                if (mem_wmask[led_byte_lane(i)]) begin
                    leds_d[i] = mem_wdata[i];
                end
            end
        end
    end

    always_comb begin
        status_word                                = '0;
        status_word[STAT_BUSY_BIT]                 = ser_busy;
        status_word[STAT_FULL_BIT]                 = fifo_full;
        status_word[STAT_EMPTY_BIT]                = fifo_empty;
        status_word[STAT_OVF_BIT]                  = ovf_q;
        // A 256-deep full FIFO shows 0 here; the full flag disambiguates
        status_word[STAT_CNT_LSB +: STAT_CNT_W]    = STAT_CNT_W'(cnt_q);

        rdata_d = rdata_q;
        if (rd_en) begin
            case (mem_addr)
                REG_LEDS:   rdata_d = XLEN'(leds_q);
                REG_STATUS: rdata_d = status_word;
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            leds_q   <= '0;
            rdata_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            leds_q   <= leds_d;
            rdata_q  <= rdata_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset; emptiness is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (resetn && push) begin
            fifo_mem[wr_ptr_q] <= mem_wdata[7:0];
        end
    end

`ifdef SOC_IOMEM_SIM_PRINT_EN
    always_ff @(posedge clk) begin
        if (resetn && pop) begin
            $write("%c", fifo_head);
        end
    end
`endif

    uart_tx_ser #(
        .BAUD_DIV (BAUD_DIV)
    ) u_ser (
        .clk      (clk),
        .resetn   (resetn),
        .tx_data  (fifo_head),
        .tx_valid (!fifo_empty),
        .tx_ready (ser_ready),
        .tx_busy  (ser_busy),
        .tx_out   (uart_tx)
    );

    assign leds      = leds_q;
    assign mem_rdata = rdata_q;

endmodule

// File: doc/soc_iomem.md
SOC_IOMEM -- requirements
Module: soc_iomem

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the data bus width.
REQ-002 The block SHALL have parameter NUM_LEDS, default 4, meaning the LED output width (1..XLEN).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 16, meaning the console TX FIFO entries (power of two, 2..256).
REQ-004 The block SHALL have parameter BAUD_DIV, default 868, meaning clk cycles per UART bit (>=2).
REQ-005 The block SHALL have port clk  input  1  meaning the single clock; all logic on posedge.
REQ-006 The block SHALL have port resetn  input  1  meaning the reset, synchronous and active-low.
REQ-007 The block SHALL have port sel  input  1  meaning the iomem select (address bit 22 decoded upstream).
REQ-008 The block SHALL have port mem_addr  input  22  meaning the byte offset within iomem.
REQ-009 The block SHALL have port mem_wdata  input  XLEN  meaning the write data.
REQ-010 The block SHALL have port mem_wmask  input  4  meaning the byte write mask; write strobe = sel & |mem_wmask.
REQ-011 The block SHALL have port mem_rstrb  input  1  meaning the read strobe.
REQ-012 The block SHALL have port mem_rdata  output  XLEN  meaning the registered read data.
REQ-013 The block SHALL have port leds  output  NUM_LEDS  meaning the LED register.
REQ-014 The block SHALL have port uart_tx  output  1  meaning the serial TX line, idle high.

Function
REQ-015 The register map SHALL be: 0x4 LEDS (RW, low NUM_LEDS bits); 0x8 TXDATA (W, byte in wdata[7:0]); 0xC STATUS (R; W1C bit3).
REQ-016 The STATUS fields SHALL be: bit0 tx_busy, bit1 fifo_full, bit2 fifo_empty, bit3 overflow (sticky), [15:8] fifo count, remaining bits 0.
REQ-017 mem_rdata SHALL update one cycle after sel & mem_rstrb and hold otherwise; unmapped offsets SHALL read 0.
REQ-018 Writes to unmapped offsets and reads of TXDATA SHALL have no effect and return 0.
REQ-019 A TXDATA write while not full SHALL push the byte; a write while full with no pop that cycle SHALL drop the byte and set overflow.
REQ-020 A push and pop in the same cycle SHALL both occur; the count SHALL remain unchanged, including when full.
REQ-021 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL saturate at FIFO_DEPTH and encode it exactly (count width log2(FIFO_DEPTH)+1).
REQ-022 The UART FSM SHALL have states IDLE, START, DATA, STOP; frame 8N1, LSB first, each bit BAUD_DIV cycles.
REQ-023 In IDLE with FIFO non-empty, the FSM SHALL pop the head byte and enter START on the next cycle.
REQ-024 DATA SHALL shift 8 bits; after STOP's last cycle the FSM SHALL return to IDLE, or start the next byte immediately if non-empty (no idle gap).
REQ-025 tx_busy SHALL be 1 in every state other than IDLE.
REQ-026 A W1C to STATUS bit3 simultaneous with an overflow event SHALL leave overflow set.

Reset
REQ-027 On resetn low at posedge: leds=0, mem_rdata=0, uart_tx=1, FSM=IDLE, FIFO empty, overflow=0, baud counter=0.
REQ-028 Reset mid-frame SHALL abort the frame, drive uart_tx high the following cycle, and discard FIFO contents.

Configuration
REQ-029 With SOC_IOMEM_SIM_PRINT_EN defined, each popped byte SHALL also be emitted via $write("%c") and stdout flushed; without it, no simulation tasks SHALL be compiled and UART behaviour SHALL be identical.

Structure
REQ-030 A shared package soc_pkg SHALL hold register offsets (LEDS/TXDATA/STATUS), STATUS bit positions, and the UART state encoding.
REQ-031 The UART serializer SHALL be a sub-module uart_tx_ser (byte + valid in, ready out, serial out); FIFO and decode stay in soc_iomem.

Verification (BAUD_DIV=4, FIFO_DEPTH=4)
REQ-032 Write LEDS=0xA, read 0x4 -> leds=0xA and mem_rdata=0xA one cycle after rstrb.
REQ-033 Write TXDATA 0x55 -> uart_tx low 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, high stop 4 cycles; busy=1 for 40 cycles.
REQ-034 Burst 6 bytes back-to-back -> first popped, 4 queued, 6th dropped, STATUS reads full=1 and overflow=1; W1C bit3 -> overflow=0.
REQ-035 Two queued bytes -> second start bit begins the cycle after the first stop bit ends; STATUS empty=1 after the second pop.
REQ-036 Assert resetn low at cycle 10 of a frame -> uart_tx=1 next cycle, STATUS reads 0x4 (empty), leds=0.
